calc_feeder: RTL and testbench
==============================

CALC_FEEDER -- requirements
Module: calc_feeder

Interface
REQ-001 Parameter WIN_LEN, default 16, samples per window (range 2..1024).
REQ-002 Parameter G_STEP, default 1, g-address offset between consecutive windows.
REQ-003 Parameter ADDR_W, default 10, pixel memory address width.
REQ-004 Port clk  in  1  single clock; all logic on rising edge.
REQ-005 Port rst  in  1  synchronous active-high reset.
REQ-006 Port start  in  1  one-cycle request to stream one 4-window job.
REQ-007 Port base_f  in  ADDR_W  f-row start address; sampled when start is accepted.
REQ-008 Port base_g  in  ADDR_W  g-row start address; sampled when start is accepted.
REQ-009 Port f_addr / g_addr  out  ADDR_W each  pixel memory read addresses.
REQ-010 Port rd_en  out  1  memory read strobe.
REQ-011 Port f_rdata / g_rdata  in  3 each  read data, valid exactly 1 cycle after rd_en.
REQ-012 Port startsig  out  1  accumulator clear pulse.
REQ-013 Port work  out  1  accumulator beat strobe; the consumer acts on its rising edge.
REQ-014 Port change  out  1  window-advance flag; qualifies work.
REQ-015 Port fdata / gdata  out  3 each  sample pair delivered with work.
REQ-016 Port busy  out  1  job in progress.
REQ-017 Port done  out  1  one-cycle completion pulse.

Function
REQ-018 The block SHALL use the FSM states IDLE, CLR, GAP, FETCH, SETUP, STROBE, TSETUP, TSTROBE and FIN.
REQ-019 IDLE SHALL accept start=1 by latching both bases, clearing win and idx, and moving to CLR.
REQ-020 CLR SHALL drive startsig=1 for exactly 1 cycle; GAP SHALL follow with startsig=0.
REQ-021 FETCH SHALL drive rd_en=1 with f_addr=base_f+idx and g_addr=base_g+win*G_STEP+idx, both taken mod 2^ADDR_W.
REQ-022 SETUP SHALL register f_rdata/g_rdata into fdata/gdata and set change=1 when idx==0 and change=0 otherwise, with work=0.
REQ-023 STROBE SHALL drive work=1 while holding fdata, gdata and change unchanged from SETUP.
REQ-024 After STROBE the block SHALL go to FETCH with idx+1 when idx<WIN_LEN-1, to FETCH with idx=0 and win+1 when idx==WIN_LEN-1 and win<3, and to TSETUP otherwise.
REQ-025 TSETUP SHALL drive change=1 with fdata=gdata=0 and work=0; TSTROBE SHALL drive work=1 holding those values; this terminating beat closes window 3.
REQ-026 FIN SHALL drive done=1 for 1 cycle and then return to IDLE.
REQ-027 busy SHALL be 1 in every state from CLR through TSTROBE and 0 in IDLE and FIN.
REQ-028 Job length SHALL be exactly 2 + 12*WIN_LEN + 2 cycles from CLR entry to FIN entry.
REQ-029 Each window SHALL produce exactly WIN_LEN work pulses, the first with change=1; 4*WIN_LEN+1 work pulses SHALL occur per job.
REQ-030 work SHALL never be high on two consecutive cycles, and change, fdata and gdata SHALL change only in cycles where work=0.
REQ-031 start SHALL be ignored while busy=1 or in FIN, with no effect on the latched bases.
REQ-032 An address sum exceeding 2^ADDR_W-1 SHALL wrap modulo 2^ADDR_W with no error flag.
REQ-033 rd_en SHALL be 0 outside FETCH, and startsig, work and done SHALL be 0 in every state that does not explicitly drive them.

Reset
REQ-034 rst=1 SHALL force state IDLE and clear win, idx, the latched bases, f_addr, g_addr, rd_en, startsig, work, change, fdata, gdata, busy and done to 0 at the next rising edge.
REQ-035 rst asserted mid-job SHALL abort the job with no further work, startsig or done pulse, and no done for the aborted job.
REQ-036 rst SHALL take priority over a start asserted in the same cycle.

Verification
REQ-037 WIN_LEN=4, G_STEP=1, base_f=0, base_g=8, memory f[a]=a&7, g[a]=(a+1)&7 -> 1 startsig, then 17 work pulses; window 0 delivers f=0,1,2,3 / g=1,2,3,4 with change=1,0,0,0; window 3 g-addresses are 11..14; done is seen 52 cycles after CLR entry.
REQ-038 Checker model mirroring the accumulator (clear on startsig, load on change, add otherwise, halt after the 4th change) -> per-window gsum is 10,14,18,22 for the REQ-037 stimulus.
REQ-039 ADDR_W=4, base_g=14, G_STEP=1 -> window 0 g_addr sequence 14,15,0,1 (wrap-around).
REQ-040 start pulsed mid-job with different bases -> job unaffected, exactly one done, next start in IDLE uses the new bases.
REQ-041 rst asserted in STROBE of window 2 -> all outputs 0 the next cycle, no done; a following start runs a full clean job.
REQ-042 start and rst high in the same cycle -> remains IDLE with busy=0.

Source files
------------

// File: rtl/calc_feeder.sv
// -----------------------------------------------------------------------------
// calc_feeder
//
// Streams one 4-window correlation job into a downstream accumulator.
// For each window it walks WIN_LEN sample pairs. It reads f from
// base_f+idx and g from base_g+win*G_STEP+idx. Each pair is delivered as
// one work beat, and the first beat of each window carries change=1.
// After the fourth window a terminating beat (change=1, zero data) closes
// the last window.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE.
// rd_en is a read strobe whose data (f_rdata/g_rdata) is valid exactly one
// cycle later. work is a one-cycle beat strobe. change, fdata and gdata are
// stable for the whole cycle before work rises and for the work cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             job request (ignored unless idle)
//   base_f, base_g    row start addresses, latched when start is accepted
//   f_addr, g_addr    pixel memory read addresses (zero when not reading)
//   rd_en             memory read strobe
//   f_rdata, g_rdata  read data, one cycle after rd_en
//   startsig          accumulator clear pulse
//   work              accumulator beat strobe
//   change            window-advance flag qualifying work
//   fdata, gdata      sample pair delivered with work
//   busy              job in progress (CLR..TSTROBE)
//   done              one-cycle completion pulse
//   dbg_state         current FSM state encoding
// -----------------------------------------------------------------------------
module calc_feeder #(
    parameter int WIN_LEN = 16,
    parameter int G_STEP  = 1,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_f,
    input  logic [ADDR_W-1:0] base_g,
    output logic [ADDR_W-1:0] f_addr,
    output logic [ADDR_W-1:0] g_addr,
    output logic              rd_en,
    input  logic [2:0]        f_rdata,
    input  logic [2:0]        g_rdata,
    output logic              startsig,
    output logic              work,
    output logic              change,
    output logic [2:0]        fdata,
    output logic [2:0]        gdata,
    output logic              busy,
    output logic              done,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CLR     = 4'd1,
        GAP     = 4'd2,
        FETCH   = 4'd3,
        SETUP   = 4'd4,
        STROBE  = 4'd5,
        TSETUP  = 4'd6,
        TSTROBE = 4'd7,
        FIN     = 4'd8
    } state_t;

    localparam int                IDX_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIN_LEN - 1);
    localparam logic [ADDR_W-1:0] G_STEP_A = ADDR_W'(G_STEP);

    state_t            state_q, state_d;
    logic [1:0]        win_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] base_f_q, base_g_q;
    logic [2:0]        fdata_q, gdata_q;
    logic [ADDR_W-1:0] win_off;

    // All address arithmetic is ADDR_W wide, so sums wrap naturally.
    assign win_off   = ADDR_W'(win_q) * G_STEP_A;
    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        startsig = 1'b0;
        work     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        change   = 1'b0;
        f_addr   = '0;
        g_addr   = '0;
        fdata    = fdata_q;
        gdata    = gdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = CLR;
            end
            CLR: begin
                busy     = 1'b1;
                startsig = 1'b1;
                state_d  = GAP;
            end
            GAP: begin
                busy    = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                f_addr  = base_f_q + ADDR_W'(idx_q);
                g_addr  = base_g_q + win_off + ADDR_W'(idx_q);
                state_d = SETUP;
            end
            SETUP: begin
                // Read data is shown straight away so that the pair is
                // already stable in the cycle before work rises. It is
                // captured into fdata_q/gdata_q for the strobe cycle.
                busy    = 1'b1;
                change  = (idx_q == '0);
                fdata   = f_rdata;
                gdata   = g_rdata;
                state_d = STROBE;
            end
            STROBE: begin
                busy   = 1'b1;
                work   = 1'b1;
                change = (idx_q == '0);
                if (idx_q != IDX_LAST || win_q != 2'd3) state_d = FETCH;
                else                                    state_d = TSETUP;
            end
            TSETUP: begin
                busy    = 1'b1;
                change  = 1'b1;
                fdata   = '0;
                gdata   = '0;
                state_d = TSTROBE;
            end
            TSTROBE: begin
                busy    = 1'b1;
                work    = 1'b1;
                change  = 1'b1;
                fdata   = '0;
                gdata   = '0;
                state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= '0;
            idx_q    <= '0;
            base_f_q <= '0;
            base_g_q <= '0;
            fdata_q  <= '0;
            gdata_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_f_q <= base_f;
                        base_g_q <= base_g;
                        win_q    <= '0;
                        idx_q    <= '0;
                    end
                end
                SETUP: begin
                    fdata_q <= f_rdata;
                    gdata_q <= g_rdata;
                end
                STROBE: begin
                    if (idx_q != IDX_LAST) begin
                        idx_q <= idx_q + IDX_W'(1);
                    end else if (win_q != 2'd3) begin
                        idx_q <= '0;
                        win_q <= win_q + 2'd1;
                    end
                end
                TSETUP: begin
                    // Leave zero data behind once the terminating beat ends.
                    fdata_q <= '0;
                    gdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_feeder.sv
module tb_calc_feeder;

    localparam int WIN_LEN = 4;
    localparam int G_STEP  = 1;
    localparam int ADDR_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_f = '0;
    logic [ADDR_W-1:0] base_g = '0;
    logic [ADDR_W-1:0] f_addr, g_addr;
    logic              rd_en;
    logic [2:0]        f_rdata = 3'd0;
    logic [2:0]        g_rdata = 3'd0;
    logic              startsig, work, change;
    logic [2:0]        fdata, gdata;
    logic              busy, done;
    logic [3:0]        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Hand-computed beats for base_f=0, base_g=8, f[a]=a&7, g[a]=(a+1)&7.
    logic [2:0] exp_f_tab [17] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3,
                                   3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [2:0] exp_g_tab [17] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4, 3'd5,
                                   3'd3, 3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic       exp_c_tab [17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int         exp_sum_tab [4] = '{10, 14, 18, 22};
    logic [ADDR_W-1:0] wrap_g_tab [4] = '{4'd14, 4'd15, 4'd0, 4'd1};

    // ---------------- clock / DUT / memory ----------------
    always #5 clk = ~clk;

    calc_feeder #(
        .WIN_LEN (WIN_LEN),
        .G_STEP  (G_STEP),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_f    (base_f),
        .base_g    (base_g),
        .f_addr    (f_addr),
        .g_addr    (g_addr),
        .rd_en     (rd_en),
        .f_rdata   (f_rdata),
        .g_rdata   (g_rdata),
        .startsig  (startsig),
        .work      (work),
        .change    (change),
        .fdata     (fdata),
        .gdata     (gdata),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Synchronous pixel memory: f[a]=a&7, g[a]=(a+1)&7.
    always @(posedge clk) begin
        if (rd_en) begin
            f_rdata <= f_addr[2:0];
            g_rdata <= g_addr[2:0] + 3'd1;
        end
    end

    // ---------------- monitor (sampled on falling edge) ----------------
    int cyc = 0;
    int n_work = 0, n_startsig = 0, n_done = 0;
    int n_consec = 0, n_chg_in_work = 0, n_busy_in_fin = 0;
    int clr_cyc = 0, done_cyc = 0;
    logic [2:0]        wf[$], wg[$];
    logic              wc[$];
    logic [ADDR_W-1:0] rd_f_q[$], rd_g_q[$];
    logic              prev_work = 1'b0, prev_c = 1'b0;
    logic [2:0]        prev_f = 3'd0, prev_g = 3'd0;

    always @(negedge clk) begin
        cyc++;
        if (work === 1'b1) begin
            n_work++;
            wf.push_back(fdata);
            wg.push_back(gdata);
            wc.push_back(change);
            if (prev_work === 1'b1) n_consec++;
            if (fdata !== prev_f || gdata !== prev_g || change !== prev_c) n_chg_in_work++;
        end
        if (startsig === 1'b1) begin
            n_startsig++;
            clr_cyc = cyc;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
            if (busy !== 1'b0) n_busy_in_fin++;
        end
        if (rd_en === 1'b1) begin
            rd_f_q.push_back(f_addr);
            rd_g_q.push_back(g_addr);
        end
        prev_work = work;
        prev_f    = fdata;
        prev_g    = gdata;
        prev_c    = change;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        @(posedge clk); #1;
        n_work = 0; n_startsig = 0; n_done = 0;
        n_consec = 0; n_chg_in_work = 0; n_busy_in_fin = 0;
        clr_cyc = 0; done_cyc = 0;
        wf.delete(); wg.delete(); wc.delete();
        rd_f_q.delete(); rd_g_q.delete();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] bf, input logic [ADDR_W-1:0] bg);
        @(posedge clk); #1;
        base_f = bf;
        base_g = bg;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({f_addr, g_addr, rd_en, startsig, work, change, fdata, gdata, busy, done, dbg_state} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got f_addr=%0d g_addr=%0d rd_en=%0b startsig=%0b work=%0b change=%0b fdata=%0d gdata=%0d busy=%0b done=%0b state=%0d, expected all 0",
                     f_addr, g_addr, rd_en, startsig, work, change, fdata, gdata, busy, done, dbg_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || dbg_state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got busy=%0b state=%0d, expected busy=0 state=0", busy, dbg_state);
        end
    endtask

    task automatic test_job();
        bit ok;
        int acc, nwin;
        int sums[$];
        clear_logs();
        do_start(4'd0, 4'd8);
        wait_done(200, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL job_done_seen: got no done within 200 cycles, expected done");
        end
        n_tests++;
        if (n_startsig !== 1) begin
            n_fail++;
            $display("FAIL job_startsig_count: got %0d, expected 1", n_startsig);
        end
        n_tests++;
        if (n_work !== 17) begin
            n_fail++;
            $display("FAIL job_work_count: got %0d, expected 17", n_work);
        end
        for (int k = 0; k < 17; k++) begin
            n_tests++;
            if (k >= wf.size()) begin
                n_fail++;
                $display("FAIL job_beat_%0d: got no beat, expected c=%0b f=%0d g=%0d",
                         k, exp_c_tab[k], exp_f_tab[k], exp_g_tab[k]);
            end else if ({wc[k], wf[k], wg[k]} !== {exp_c_tab[k], exp_f_tab[k], exp_g_tab[k]}) begin
                n_fail++;
                $display("FAIL job_beat_%0d: got c=%0b f=%0d g=%0d, expected c=%0b f=%0d g=%0d",
                         k, wc[k], wf[k], wg[k], exp_c_tab[k], exp_f_tab[k], exp_g_tab[k]);
            end
        end
        // Accumulator model: clear on startsig (logs were cleared), load on
        // change, add otherwise; the change that follows window 3 ends it.
        acc = 0;
        nwin = 0;
        for (int k = 0; k < wf.size(); k++) begin
            if (wc[k] === 1'b1) begin
                if (nwin > 0) sums.push_back(acc);
                if (nwin == 4) break;
                nwin++;
                acc = int'(wg[k]);
            end else begin
                acc += int'(wg[k]);
            end
        end
        n_tests++;
        if (sums.size() !== 4) begin
            n_fail++;
            $display("FAIL job_gsum_count: got %0d windows, expected 4", sums.size());
        end
        for (int w = 0; w < 4; w++) begin
            if (w < sums.size()) begin
                n_tests++;
                if (sums[w] !== exp_sum_tab[w]) begin
                    n_fail++;
                    $display("FAIL job_gsum_w%0d: got %0d, expected %0d", w, sums[w], exp_sum_tab[w]);
                end
            end
        end
        n_tests++;
        if (rd_g_q.size() !== 16) begin
            n_fail++;
            $display("FAIL job_read_count: got %0d, expected 16", rd_g_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (rd_g_q[12+i] !== ADDR_W'(11 + i) || rd_f_q[12+i] !== ADDR_W'(i)) begin
                    n_fail++;
                    $display("FAIL job_w3_addr_%0d: got f=%0d g=%0d, expected f=%0d g=%0d",
                             i, rd_f_q[12+i], rd_g_q[12+i], i, 11 + i);
                end
            end
        end
        n_tests++;
        if (done_cyc - clr_cyc !== 52) begin
            n_fail++;
            $display("FAIL job_latency: got %0d, expected 52", done_cyc - clr_cyc);
        end
        n_tests++;
        if (n_done !== 1 || n_busy_in_fin !== 0) begin
            n_fail++;
            $display("FAIL job_done_pulse: got done=%0d busy_in_fin=%0d, expected 1 and 0", n_done, n_busy_in_fin);
        end
        n_tests++;
        if (n_consec !== 0 || n_chg_in_work !== 0) begin
            n_fail++;
            $display("FAIL job_beat_shape: got consecutive=%0d data_change_in_work=%0d, expected 0 and 0",
                     n_consec, n_chg_in_work);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_logs();
        do_start(4'd0, 4'd14);
        wait_done(200, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok || n_done !== 1) begin
            n_fail++;
            $display("FAIL wrap_done: got seen=%0b count=%0d, expected 1 and 1", ok, n_done);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= rd_g_q.size()) begin
                n_fail++;
                $display("FAIL wrap_g_addr_%0d: got no read, expected %0d", i, wrap_g_tab[i]);
            end else if (rd_g_q[i] !== wrap_g_tab[i]) begin
                n_fail++;
                $display("FAIL wrap_g_addr_%0d: got %0d, expected %0d", i, rd_g_q[i], wrap_g_tab[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_logs();
        do_start(4'd0, 4'd8);
        repeat (10) @(posedge clk);
        #1;
        base_f = 4'd5;
        base_g = 4'd3;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        wait_done(200, ok);
        repeat (20) @(negedge clk);
        n_tests++;
        if (!ok || n_done !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_single_done: got seen=%0b count=%0d busy=%0b, expected 1, 1, 0", ok, n_done, busy);
        end
        for (int k = 0; k < 17; k++) begin
            n_tests++;
            if (k >= wg.size()) begin
                n_fail++;
                $display("FAIL ignore_beat_%0d: got no beat, expected f=%0d g=%0d", k, exp_f_tab[k], exp_g_tab[k]);
            end else if ({wf[k], wg[k]} !== {exp_f_tab[k], exp_g_tab[k]}) begin
                n_fail++;
                $display("FAIL ignore_beat_%0d: got f=%0d g=%0d, expected f=%0d g=%0d",
                         k, wf[k], wg[k], exp_f_tab[k], exp_g_tab[k]);
            end
        end
        clear_logs();
        do_start(4'd5, 4'd3);
        wait_done(200, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (rd_f_q.size() < 2) begin
            n_fail++;
            $display("FAIL ignore_new_bases: got %0d reads, expected 16", rd_f_q.size());
        end else if (rd_f_q[0] !== 4'd5 || rd_g_q[0] !== 4'd3 || rd_f_q[1] !== 4'd6 || rd_g_q[1] !== 4'd4) begin
            n_fail++;
            $display("FAIL ignore_new_bases: got f=%0d,%0d g=%0d,%0d, expected f=5,6 g=3,4",
                     rd_f_q[0], rd_f_q[1], rd_g_q[0], rd_g_q[1]);
        end
    endtask

    task automatic test_reset_midjob();
        bit ok, hit;
        int cnt, gtotal;
        clear_logs();
        do_start(4'd0, 4'd8);
        cnt = 0;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (work === 1'b1) cnt++;
            if (cnt == 9) begin
                hit = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL midrst_reach_w2: got %0d beats, expected 9", cnt);
        end
        // Now in the first STROBE of window 2.
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({f_addr, g_addr, rd_en, startsig, work, change, fdata, gdata, busy, done, dbg_state} !== 24'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got f_addr=%0d g_addr=%0d rd_en=%0b startsig=%0b work=%0b change=%0b fdata=%0d gdata=%0d busy=%0b done=%0b state=%0d, expected all 0",
                     f_addr, g_addr, rd_en, startsig, work, change, fdata, gdata, busy, done, dbg_state);
        end
        rst = 1'b0;
        clear_logs();
        repeat (60) @(negedge clk);
        n_tests++;
        if (n_work !== 0 || n_done !== 0 || n_startsig !== 0) begin
            n_fail++;
            $display("FAIL midrst_quiet: got work=%0d done=%0d startsig=%0d, expected 0 0 0", n_work, n_done, n_startsig);
        end
        clear_logs();
        do_start(4'd0, 4'd8);
        wait_done(200, ok);
        repeat (3) @(negedge clk);
        gtotal = 0;
        foreach (wg[k]) gtotal += int'(wg[k]);
        n_tests++;
        if (!ok || n_done !== 1 || n_work !== 17 || n_startsig !== 1 || gtotal !== 64) begin
            n_fail++;
            $display("FAIL midrst_clean_job: got seen=%0b done=%0d work=%0d startsig=%0d gtotal=%0d, expected 1 1 17 1 64",
                     ok, n_done, n_work, n_startsig, gtotal);
        end
    endtask

    task automatic test_rst_start_same();
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b1;
        base_f = 4'd2;
        base_g = 4'd2;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || dbg_state !== 4'd0 || startsig !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start_same: got busy=%0b state=%0d startsig=%0b, expected 0 0 0", busy, dbg_state, startsig);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || dbg_state !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_start_after: got busy=%0b state=%0d, expected 0 0", busy, dbg_state);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_job();
        test_wrap();
        test_start_ignored();
        test_reset_midjob();
        test_rst_start_same();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of sequence, expected finish before 200000");
        $fatal(1, "time limit reached");
    end

endmodule
